// File: rtl/catch_game_ctrl_pkg.sv
// Shared definitions for the catch game round sequencer.
//   game_state_t : FSM state encodings (also exported on game_state for display)
//   P_NONE/P1/P2 : player / glove identifiers as seen on ball_state
//   ball_owner   : maps a raw ball_state to a player id (3 reads as in the air)
package catch_game_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SERVE   = 3'd1,
    S_HELD    = 3'd2,
    S_FLIGHT  = 3'd3,
    S_DROPPED = 3'd4,
    S_OVER    = 3'd5
  } game_state_t;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P1     = 2'd1;
  localparam logic [1:0] P2     = 2'd2;

  function automatic logic [1:0] ball_owner(input logic [1:0] bs);
    return (bs == 2'd3) ? P_NONE : bs;
  endfunction

endpackage

// File: rtl/catch_game_ctrl_tick_gen.sv
// Free-running game tick divider, shareable with other game-rate blocks.
//   clk, reset : system clock, synchronous active-high reset
//   tick_c     : one-cycle pulse every DIV cycles, high while the count is 0
module catch_game_ctrl_tick_gen #(
  parameter int unsigned DIV = 210937
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Down-counter; reset clears it so the first tick follows reset immediately.
  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (cnt == '0)     cnt <= CW'(DIV - 1);
    else                    cnt <= cnt - CW'(1);
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/catch_game_ctrl.sv
// Round sequencer for the two-glove catch game: serves the ball, gates the
// glove catch enables, scores catches and drops, and ends the game.
//   clk, reset             : system clock, synchronous active-high reset
//   start                  : level, begins a game from IDLE or OVER
//   ball_state, ball_y     : ball state machine status (holder, height in mm)
//   can_catch1/can_catch2  : glove catch enables
//   ball_reset             : serve request to the ball state machine
//   catches, drops1/drops2 : scores
//   game_state, game_over  : FSM state for display, high in OVER
module catch_game_ctrl
  import catch_game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 210937,
  parameter int unsigned FLOOR_MM   = 60,
  parameter int unsigned DROP_TICKS = 64,
  parameter int unsigned SELF_TICKS = 128,
  parameter int unsigned MAX_DROPS  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ball_state,
  input  logic [15:0] ball_y,
  output logic        can_catch1,
  output logic        can_catch2,
  output logic        ball_reset,
  output logic [7:0]  catches,
  output logic [2:0]  drops1,
  output logic [2:0]  drops2,
  output logic [2:0]  game_state,
  output logic        game_over
);

  localparam int unsigned FW = $clog2(SELF_TICKS + 1);
  localparam int unsigned DW = $clog2(DROP_TICKS + 1);

  game_state_t   state, state_n;
  logic [1:0]    holder, holder_n, thrower, thrower_n, owner;
  logic [FW-1:0] flight_cnt, flight_n;
  logic [DW-1:0] floor_cnt, floor_n;
  logic [7:0]    catches_n;
  logic [2:0]    drops1_n, drops2_n, victim_drops;
  logic          can_catch1_n, can_catch2_n, ball_reset_n, game_over_n;
  logic          tick_c;

  catch_game_ctrl_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_c (tick_c)
  );

  // State, counters, scores and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      holder     <= P_NONE;
      thrower    <= P_NONE;
      flight_cnt <= '0;
      floor_cnt  <= '0;
      catches    <= '0;
      drops1     <= '0;
      drops2     <= '0;
      can_catch1 <= 1'b0;
      can_catch2 <= 1'b0;
      ball_reset <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      holder     <= holder_n;
      thrower    <= thrower_n;
      flight_cnt <= flight_n;
      floor_cnt  <= floor_n;
      catches    <= catches_n;
      drops1     <= drops1_n;
      drops2     <= drops2_n;
      can_catch1 <= can_catch1_n;
      can_catch2 <= can_catch2_n;
      ball_reset <= ball_reset_n;
      game_over  <= game_over_n;
    end
  end

  // Next state, scoring and next-cycle output values.
  always_comb begin
    state_n      = state;
    holder_n     = holder;
    thrower_n    = thrower;
    flight_n     = flight_cnt;
    floor_n      = floor_cnt;
    catches_n    = catches;
    drops1_n     = drops1;
    drops2_n     = drops2;
    victim_drops = '0;
    owner        = ball_owner(ball_state);

    case (state)
      S_IDLE: begin
        if (start) state_n = S_SERVE;
      end
      S_SERVE: begin
        if (owner != P_NONE) begin
          state_n  = S_HELD;
          holder_n = owner;
        end
      end
      S_HELD: begin
        if (owner != P_NONE) begin
          holder_n = owner;
        end else begin
          state_n   = S_FLIGHT;
          thrower_n = holder;
          flight_n  = '0;
          floor_n   = '0;
        end
      end
      S_FLIGHT: begin
        if (tick_c) begin
          if (flight_cnt < FW'(SELF_TICKS)) flight_n = flight_cnt + FW'(1);
          if (ball_y < 16'(FLOOR_MM)) begin
            if (floor_cnt < DW'(DROP_TICKS)) floor_n = floor_cnt + DW'(1);
          end else begin
            floor_n = '0;
          end
        end
        // A glove closing in the same cycle as the last floor tick still counts.
        if (owner != P_NONE) begin
          state_n  = S_HELD;
          holder_n = owner;
          if (owner != thrower && catches != 8'hFF) catches_n = catches + 8'd1;
        end else if (floor_n == DW'(DROP_TICKS)) begin
          state_n = S_DROPPED;
        end
      end
      S_DROPPED: begin
        // The player who failed to catch (the non-thrower) is charged.
        victim_drops = ((thrower == P1) ? drops2 : drops1) + 3'd1;
        if (thrower == P1) drops2_n = victim_drops;
        else               drops1_n = victim_drops;
        state_n = (victim_drops == 3'(MAX_DROPS)) ? S_OVER : S_SERVE;
      end
      S_OVER: begin
        if (start) begin
          state_n   = S_SERVE;
          catches_n = '0;
          drops1_n  = '0;
          drops2_n  = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    ball_reset_n = (state_n == S_SERVE);
    game_over_n  = (state_n == S_OVER);
    can_catch1_n = (state_n == S_FLIGHT) &&
                   ((thrower_n != P1) || (flight_n >= FW'(SELF_TICKS)));
    can_catch2_n = (state_n == S_FLIGHT) &&
                   ((thrower_n != P2) || (flight_n >= FW'(SELF_TICKS)));
  end

  assign game_state = state;

endmodule

// File: tb/tb_catch_game_ctrl.sv
// Self-checking bench for catch_game_ctrl with a fast tick (4 cycles).
// Directed scenarios plus randomized rounds scored by a round-level model.
module tb_catch_game_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned DT = 4;
  localparam int unsigned ST = 8;
  localparam int unsigned MD = 2;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  ball_state;
  logic [15:0] ball_y;
  logic        can_catch1, can_catch2, ball_reset, game_over;
  logic [7:0]  catches;
  logic [2:0]  drops1, drops2, game_state;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned edge_n;

  catch_game_ctrl #(
    .TICK_DIV(TD), .FLOOR_MM(60), .DROP_TICKS(DT), .SELF_TICKS(ST), .MAX_DROPS(MD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ball_state(ball_state), .ball_y(ball_y),
    .can_catch1(can_catch1), .can_catch2(can_catch2), .ball_reset(ball_reset),
    .catches(catches), .drops1(drops1), .drops2(drops2),
    .game_state(game_state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the controller sees a tick on edges 1, 1+TD, ...
  always @(posedge clk) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ball_state = 2'd0; ball_y = 16'd500;
    step(3);
    n_checks++;
    if (game_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", game_state); end
    n_checks++;
    if ({ball_reset, can_catch1, can_catch2, game_over} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {ball_reset, can_catch1, can_catch2, game_over});
    end
    n_checks++;
    if ({catches, drops1, drops2} !== 14'd0) begin
      n_fail++; $display("FAIL reset_scores: got %0d/%0d/%0d want 0/0/0", catches, drops1, drops2);
    end
    reset = 1'b0;
    step(2);
    n_checks++;
    if (game_state !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", game_state); end
  endtask

  task automatic test_serve();
    start = 1'b1;
    step();
    n_checks++;
    if (game_state !== 3'd1 || ball_reset !== 1'b1) begin
      n_fail++; $display("FAIL serve: state %0d ball_reset %b want 1/1", game_state, ball_reset);
    end
    start = 1'b0;
    step(3);
    n_checks++;
    if (game_state !== 3'd1) begin n_fail++; $display("FAIL serve_wait: got %0d want 1", game_state); end
    ball_state = 2'd1;
    step();
    n_checks++;
    if (game_state !== 3'd2 || ball_reset !== 1'b0) begin
      n_fail++; $display("FAIL held: state %0d ball_reset %b want 2/0", game_state, ball_reset);
    end
  endtask

  task automatic test_self_catch();
    ball_state = 2'd0;
    step();
    n_checks++;
    if (game_state !== 3'd3 || can_catch1 !== 1'b0 || can_catch2 !== 1'b1) begin
      n_fail++; $display("FAIL flight_enables: state %0d cc1 %b cc2 %b want 3/0/1", game_state, can_catch1, can_catch2);
    end
    step(7 * TD);
    n_checks++;
    if (can_catch1 !== 1'b0) begin n_fail++; $display("FAIL self_early: cc1 %b want 0", can_catch1); end
    step(TD);
    n_checks++;
    if (can_catch1 !== 1'b1 || can_catch2 !== 1'b1) begin
      n_fail++; $display("FAIL self_late: cc1 %b cc2 %b want 1/1", can_catch1, can_catch2);
    end
    ball_state = 2'd1;
    step();
    n_checks++;
    if (game_state !== 3'd2 || catches !== 8'd0) begin
      n_fail++; $display("FAIL self_recatch: state %0d catches %0d want 2/0", game_state, catches);
    end
  endtask

  task automatic test_catch();
    ball_state = 2'd0;
    step(1 + 3 * TD);
    ball_state = 2'd2;
    step();
    n_checks++;
    if (game_state !== 3'd2 || catches !== 8'd1) begin
      n_fail++; $display("FAIL catch: state %0d catches %0d want 2/1", game_state, catches);
    end
  endtask

  task automatic test_drop();
    ball_state = 2'd1;
    step();
    ball_state = 2'd0;
    step();
    ball_y = 16'd10;
    step(DT * TD + 2);
    n_checks++;
    if (game_state !== 3'd1 || drops2 !== 3'd1 || drops1 !== 3'd0 || ball_reset !== 1'b1) begin
      n_fail++; $display("FAIL drop: state %0d d1 %0d d2 %0d br %b want 1/0/1/1", game_state, drops1, drops2, ball_reset);
    end
  endtask

  task automatic test_no_drop();
    ball_y = 16'd500; ball_state = 2'd1;
    step();
    ball_state = 2'd0;
    step();
    ball_y = 16'd10;
    step((DT - 1) * TD);
    ball_y = 16'd60;
    step(6 * TD);
    n_checks++;
    if (game_state !== 3'd3 || drops2 !== 3'd1) begin
      n_fail++; $display("FAIL no_drop: state %0d d2 %0d want 3/1", game_state, drops2);
    end
    ball_state = 2'd2;
    step();
    n_checks++;
    if (game_state !== 3'd2 || catches !== 8'd2) begin
      n_fail++; $display("FAIL catch_after_floor: state %0d catches %0d want 2/2", game_state, catches);
    end
  endtask

  task automatic test_game_over();
    ball_state = 2'd1;
    step();
    ball_state = 2'd0;
    step();
    ball_y = 16'd10;
    step(DT * TD + 2);
    n_checks++;
    if (game_state !== 3'd5 || game_over !== 1'b1 || drops2 !== 3'd2) begin
      n_fail++; $display("FAIL over: state %0d go %b d2 %0d want 5/1/2", game_state, game_over, drops2);
    end
    n_checks++;
    if ({ball_reset, can_catch1, can_catch2} !== 3'b000) begin
      n_fail++; $display("FAIL over_outputs: got %b want 000", {ball_reset, can_catch1, can_catch2});
    end
    ball_y = 16'd500; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (game_state !== 3'd1 || game_over !== 1'b0 || {catches, drops1, drops2} !== 14'd0) begin
      n_fail++; $display("FAIL restart: state %0d go %b c %0d d1 %0d d2 %0d want 1/0/0/0/0",
                         game_state, game_over, catches, drops1, drops2);
    end
  endtask

  task automatic test_catch_beats_drop();
    ball_state = 2'd1;
    step();
    for (int i = 0; i < int'(TD) && (edge_n % TD) != 0; i++) step();
    ball_state = 2'd0; ball_y = 16'd10;
    step();
    step(DT * TD - 1);
    ball_state = 2'd2;
    step();
    n_checks++;
    if (game_state !== 3'd2 || catches !== 8'd1 || drops2 !== 3'd0) begin
      n_fail++; $display("FAIL catch_vs_drop: state %0d c %0d d2 %0d want 2/1/0", game_state, catches, drops2);
    end
    ball_y = 16'd500;
  endtask

  task automatic test_reset_mid_flight();
    ball_state = 2'd0;
    step(6);
    n_checks++;
    if (game_state !== 3'd3) begin n_fail++; $display("FAIL pre_reset_flight: got %0d want 3", game_state); end
    reset = 1'b1;
    step();
    n_checks++;
    if (game_state !== 3'd0 || {ball_reset, can_catch1, can_catch2, game_over} !== 4'b0000 ||
        {catches, drops1, drops2} !== 14'd0) begin
      n_fail++; $display("FAIL mid_reset: state %0d flags %b c %0d d1 %0d d2 %0d want all 0", game_state,
                         {ball_reset, can_catch1, can_catch2, game_over}, catches, drops1, drops2);
    end
    reset = 1'b0;
  endtask

  // Round-level model: whole-tick windows make the tick count per window exact.
  task automatic test_random();
    int exp_c, exp_d1, exp_d2, thr, ft, k, len, catcher;
    bit exp_over, in_serve;
    exp_c = 0; exp_d1 = 0; exp_d2 = 0; exp_over = 1'b0; in_serve = 1'b1; thr = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 40; r++) begin
      if (exp_over) begin
        start = 1'b1;
        step();
        start = 1'b0;
        exp_c = 0; exp_d1 = 0; exp_d2 = 0; exp_over = 1'b0; in_serve = 1'b1;
        n_checks++;
        if (game_state !== 3'd1 || {catches, drops1, drops2} !== 14'd0) begin
          n_fail++; $display("FAIL rnd_restart r%0d: state %0d want 1", r, game_state);
        end
      end
      if (in_serve || $urandom_range(0, 1) == 1) begin
        thr = in_serve ? int'($urandom_range(1, 2)) : 3 - thr;
        ball_state = 2'(thr);
        step();
        in_serve = 1'b0;
        n_checks++;
        if (game_state !== 3'd2 || ball_reset !== 1'b0) begin
          n_fail++; $display("FAIL rnd_held r%0d: state %0d br %b want 2/0", r, game_state, ball_reset);
        end
      end
      step(int'($urandom_range(0, 2)));
      ball_state = 2'd0; ball_y = 16'(60 + $urandom_range(0, 999));
      step();
      ft = 0;
      k = int'($urandom_range(0, 10));
      step(k * int'(TD));
      ft += k;
      n_checks++;
      if (game_state !== 3'd3 || (thr == 1 ? can_catch1 : can_catch2) !== (ft >= int'(ST)) ||
          (thr == 1 ? can_catch2 : can_catch1) !== 1'b1) begin
        n_fail++; $display("FAIL rnd_enables r%0d: state %0d cc1 %b cc2 %b thrower %0d ticks %0d",
                           r, game_state, can_catch1, can_catch2, thr, ft);
      end
      if ($urandom_range(0, 1) == 1) begin
        len = int'($urandom_range(1, 6));
        ball_y = 16'($urandom_range(0, 59));
        step(len * int'(TD));
        if (len >= int'(DT)) begin
          step(2);
          if (thr == 1) exp_d2++; else exp_d1++;
          exp_over = (exp_d1 == int'(MD)) || (exp_d2 == int'(MD));
          in_serve = !exp_over;
          ball_y = 16'd500;
          n_checks++;
          if (game_state !== (exp_over ? 3'd5 : 3'd1) || drops1 !== 3'(exp_d1) || drops2 !== 3'(exp_d2) ||
              game_over !== exp_over) begin
            n_fail++; $display("FAIL rnd_drop r%0d: state %0d d1 %0d d2 %0d want over=%0d d1 %0d d2 %0d",
                               r, game_state, drops1, drops2, exp_over, exp_d1, exp_d2);
          end
          continue;
        end
        ft += len;
        ball_y = 16'(60 + $urandom_range(0, 999));
      end
      catcher = int'($urandom_range(1, 2));
      ball_state = 2'(catcher);
      step();
      if (catcher != thr) exp_c++;
      thr = catcher;
      n_checks++;
      if (game_state !== 3'd2 || catches !== 8'(exp_c)) begin
        n_fail++; $display("FAIL rnd_catch r%0d: state %0d catches %0d want 2/%0d", r, game_state, catches, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_self_catch();
    test_catch();
    test_drop();
    test_no_drop();
    test_game_over();
    ball_state = 2'd1;
    step();
    test_catch_beats_drop();
    test_reset_mid_flight();
    ball_state = 2'd0; ball_y = 16'd500;
    step(2);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
